// File: rtl/gray2bin.sv
// Streams a BMP-style image from a gray RAM to a binary RAM: header bytes pass through,
// pixel triples are thresholded to 0x00/0xFF and white pixels are counted.
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BMP_HEADER_SIZE
`define BMP_HEADER_SIZE 6
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 21
`endif

// state | meaning
// IDLE  | waiting for in_valid after reset
// RD    | src RAM read issued for addr
// WR    | src_Q valid, dst RAM written at addr
// DONE  | image finished, white_cnt held, waiting for restart
module gray2bin (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [`BYTE_WIDTH-1:0]  threshold,
  input  logic [`BYTE_WIDTH-1:0]  src_Q,
  output logic                    src_ren,
  output logic [`ADDR_WIDTH-1:0]  src_addr,
  output logic                    dst_wen,
  output logic [`BYTE_WIDTH-1:0]  dst_D,
  output logic [`ADDR_WIDTH-1:0]  dst_addr,
  output logic [`ADDR_WIDTH-1:0]  white_cnt,
  output logic                    bin_done
);

  localparam int AW = `ADDR_WIDTH;
  localparam int BW = `BYTE_WIDTH;
  localparam logic [AW-1:0] HDR_END   = AW'(`BMP_HEADER_SIZE);
  localparam logic [AW-1:0] ADDR_LAST = AW'(`BMP_TOTAL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr, addr_nxt;
  logic [1:0]      ch, ch_nxt;
  logic [BW-1:0]   bin_q, bin_nxt;
  logic [BW-1:0]   thr_q, thr_nxt;
  logic [AW-1:0]   white_nxt;
  logic [BW-1:0]   bin_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      ch        <= '0;
      bin_q     <= '0;
      thr_q     <= '0;
      white_cnt <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      ch        <= ch_nxt;
      bin_q     <= bin_nxt;
      thr_q     <= thr_nxt;
      white_cnt <= white_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ch_nxt    = ch;
    bin_nxt   = bin_q;
    thr_nxt   = thr_q;
    white_nxt = white_cnt;
    src_ren   = 1'b0;
    dst_wen   = 1'b0;
    dst_D     = '0;
    bin_done  = 1'b0;
    bin_cur   = (src_Q >= thr_q) ? {BW{1'b1}} : {BW{1'b0}};

    case (state)
      IDLE, DONE: begin
        bin_done = (state == DONE);
        if (in_valid) begin
          state_nxt = RD;
          addr_nxt  = '0;
          ch_nxt    = '0;
          white_nxt = '0;
          thr_nxt   = threshold;
        end
      end
      RD: begin
        src_ren   = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        dst_wen = 1'b1;
        if (addr < HDR_END) begin
          dst_D = src_Q;
        end else begin
          // Only the B byte is compared; G and R reuse its result.
          if (ch == 2'd0) begin
            dst_D   = bin_cur;
            bin_nxt = bin_cur;
            if (bin_cur == {BW{1'b1}})
              white_nxt = white_cnt + AW'(1);
          end else begin
            dst_D = bin_q;
          end
          ch_nxt = (ch == 2'd2) ? 2'd0 : ch + 2'd1;
        end
        if (addr < ADDR_LAST) begin
          addr_nxt  = addr + AW'(1);
          state_nxt = RD;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign src_addr = addr;
  assign dst_addr = addr;

endmodule

// File: tb/tb_gray2bin.sv
// Table-driven bench for gray2bin: a RAM model feeds images, a queue scoreboard holds
// the expected dst writes, and run timing, white count and reset behaviour are checked.
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BMP_HEADER_SIZE
`define BMP_HEADER_SIZE 6
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 21
`endif

module tb_gray2bin;

  localparam int H = `BMP_HEADER_SIZE;
  localparam int T = `BMP_TOTAL_SIZE;
  localparam int NPIX = (T - H) / 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic [`BYTE_WIDTH-1:0] threshold;
  logic [`BYTE_WIDTH-1:0] src_Q;
  logic                   src_ren;
  logic [`ADDR_WIDTH-1:0] src_addr;
  logic                   dst_wen;
  logic [`BYTE_WIDTH-1:0] dst_D;
  logic [`ADDR_WIDTH-1:0] dst_addr;
  logic [`ADDR_WIDTH-1:0] white_cnt;
  logic                   bin_done;

  gray2bin dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .threshold(threshold),
    .src_Q(src_Q), .src_ren(src_ren), .src_addr(src_addr), .dst_wen(dst_wen),
    .dst_D(dst_D), .dst_addr(dst_addr), .white_cnt(white_cnt), .bin_done(bin_done)
  );

  always #5 clk = ~clk;

  logic [7:0] src_mem [256];
  always @(posedge clk) if (src_ren) src_Q <= src_mem[src_addr];

  typedef struct {
    logic [7:0]      thr;
    logic [0:4][7:0] px;
    bit              scramble;
    int              exp_white;
  } case_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  case_t cases [5];
  wr_t   sb [$];
  int    errors = 0;
  int    checks = 0;
  logic [7:0] hdr [6] = '{8'h42, 8'h4D, 8'h36, 8'h00, 8'h01, 8'h02};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " src_ren"}, int'(src_ren), 0);
    check({name, " dst_wen"}, int'(dst_wen), 0);
    check({name, " dst_D"}, int'(dst_D), 0);
    check({name, " bin_done"}, int'(bin_done), 0);
    check({name, " white_cnt"}, int'(white_cnt), 0);
    check({name, " src_addr"}, int'(src_addr), 0);
  endtask

  // Loads the image into the RAM model and queues the expected write stream.
  task automatic load_case(input int idx);
    logic [7:0] g;
    logic [7:0] e;
    sb.delete();
    for (int i = 0; i < T; i++) begin
      if (i < H) begin
        src_mem[i] = hdr[i];
        e = hdr[i];
      end else begin
        g = cases[idx].px[(i - H) / 3];
        case ((i - H) % 3)
          0:       src_mem[i] = g;
          1:       src_mem[i] = cases[idx].scramble ? (g ^ 8'h5A) : g;
          default: src_mem[i] = cases[idx].scramble ? ~g : g;
        endcase
        e = (g >= cases[idx].thr) ? 8'hFF : 8'h00;
      end
      sb.push_back('{addr: i, data: int'(e)});
    end
  endtask

  // abort_at > 0 pulls rst_n low at that cycle of the run instead of completing it.
  task automatic run_case(input int idx, input int abort_at);
    int k;
    int nwr;
    wr_t w;
    load_case(idx);
    @(negedge clk);
    threshold = cases[idx].thr;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    nwr = 0;
    while (!bin_done && k < 3 * T) begin
      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid-run reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (src_ren && dst_wen) check("ren/wen overlap", 1, 0);
      if (k == T) begin
        threshold = ~cases[idx].thr;
        in_valid  = 1'b1;
      end
      if (k == T + 1) in_valid = 1'b0;
      if (dst_wen) begin
        nwr++;
        if (sb.size() == 0) begin
          check("unexpected write", int'(dst_addr), -1);
        end else begin
          w = sb.pop_front();
          check($sformatf("case%0d wr addr", idx), int'(dst_addr), w.addr);
          check($sformatf("case%0d wr data @%0d", idx, w.addr), int'(dst_D), w.data);
        end
      end
      @(negedge clk);
      k++;
    end
    check($sformatf("case%0d done cycle", idx), k, 2 * T);
    check($sformatf("case%0d write count", idx), nwr, T);
    check($sformatf("case%0d leftover", idx), sb.size(), 0);
    check($sformatf("case%0d white_cnt", idx), int'(white_cnt), cases[idx].exp_white);
    check($sformatf("case%0d dst_D in DONE", idx), int'(dst_D), 0);
    repeat (3) @(negedge clk);
    check($sformatf("case%0d done held", idx), int'(bin_done), 1);
    check($sformatf("case%0d white held", idx), int'(white_cnt), cases[idx].exp_white);
    check($sformatf("case%0d addr held", idx), int'(dst_addr), T - 1);
  endtask

  initial begin
    cases[0] = '{thr: 8'd128, px: '{8'd127, 8'd128, 8'd0, 8'd5, 8'd100},   scramble: 1'b0, exp_white: 1};
    cases[1] = '{thr: 8'd0,   px: '{8'd0, 8'd1, 8'd50, 8'd127, 8'd255},    scramble: 1'b1, exp_white: NPIX};
    cases[2] = '{thr: 8'd255, px: '{8'd254, 8'd255, 8'd0, 8'd128, 8'd255}, scramble: 1'b0, exp_white: 2};
    cases[3] = '{thr: 8'd1,   px: '{8'd0, 8'd1, 8'd2, 8'd0, 8'd0},         scramble: 1'b1, exp_white: 2};
    cases[4] = '{thr: 8'd128, px: '{8'd200, 8'd127, 8'd128, 8'd129, 8'd255}, scramble: 1'b0, exp_white: 4};

    rst_n = 1'b0;
    in_valid = 1'b0;
    threshold = 8'd0;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_outputs("in reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("after release");

    for (int c = 0; c < 4; c++) run_case(c, 0);
    run_case(4, 2 * H + 9);
    repeat (2) @(negedge clk);
    check_idle_outputs("idle after reset");
    run_case(4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
